cpu_sequencer: RTL and testbench

Multi-cycle control unit for the 8-register CPU core. It fetches one- or two-byte instructions over a req/ready memory handshake and holds the instruction and operand bytes internally. It decodes them and drives the register-file, ALU, PC and memory strobes for each instruction. It owns `c_halt`, which the system bench watches to dump the register file.

---
 rtl/cpu_sequencer.sv | 140 ++++++++++++++
 tb/tb_cpu_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute control unit for the 8-register CPU core.
// Strobes are decoded from state and IR and are forced low while reset is asserted.
module cpu_sequencer #(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       mem_addr_sel_o,
    input  logic       mem_ready_i,
    input  logic [7:0] mem_rdata_i,
    output logic       pc_inc_o,
    output logic       pc_load_o,
    output logic [2:0] alu_op_o,
    output logic       alu_src_imm_o,
    output logic       rf_we_o,
    output logic       wb_sel_o,
    output logic [2:0] rf_waddr_o,
    output logic [2:0] rf_raddr_b_o,
    output logic [7:0] imm_o,
    input  logic       flag_z_i,
    output logic       c_halt_o,
    output logic       err_o
);
    localparam int WW = $clog2(WAIT_MAX + 1);
    localparam logic [WW-1:0] WMAX = WW'(WAIT_MAX);

    typedef enum logic [2:0] {S_FETCH_OP, S_FETCH_OPND, S_EXEC, S_MEM, S_HALT} state_t;

    state_t          state_q, state_d;
    logic [7:0]      ir_q, ir_d;
    logic [7:0]      opnd_q, opnd_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic            err_q, err_d;
    logic            req, we, asel, inc, load, src_imm, rf_we, wb;
    logic [2:0]      alu_op;
    logic [3:0]      op, rd_op;
    logic            alu_cls;

    assign op      = ir_q[7:4];
    assign rd_op   = mem_rdata_i[7:4];
    assign alu_cls = op inside {[4'h1:4'h6]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH_OP;
            ir_q    <= '0;
            opnd_q  <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            opnd_q  <= opnd_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        opnd_d  = opnd_q;
        err_d   = err_q;
        wait_d  = '0;
        req     = 1'b0;
        we      = 1'b0;
        asel    = 1'b0;
        inc     = 1'b0;
        load    = 1'b0;
        alu_op  = 3'd0;
        src_imm = 1'b0;
        rf_we   = 1'b0;
        wb      = 1'b0;
        case (state_q)
            S_FETCH_OP: begin
                req = 1'b1;
                if (mem_ready_i) begin
                    ir_d    = mem_rdata_i;
                    inc     = 1'b1;
                    state_d = (rd_op == 4'h0 || rd_op == 4'hF) ? S_EXEC :
                              (rd_op > 4'hA) ? S_HALT : S_FETCH_OPND;
                    err_d   = rd_op inside {[4'hB:4'hE]};
                end
            end
            S_FETCH_OPND: begin
                req = 1'b1;
                if (mem_ready_i) begin
                    opnd_d  = mem_rdata_i;
                    inc     = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = (op == 4'h7 || op == 4'h8) ? S_MEM :
                          (op == 4'hF) ? S_HALT : S_FETCH_OP;
                rf_we   = alu_cls;
                alu_op  = alu_cls ? op[2:0] - 3'd1 : 3'd0;
                src_imm = alu_cls & ir_q[3];
                load    = (op == 4'h9) | ((op == 4'hA) & flag_z_i);
            end
            S_MEM: begin
                req  = 1'b1;
                asel = 1'b1;
                we   = op == 4'h8;
                if (mem_ready_i) begin
                    rf_we   = op == 4'h7;
                    wb      = op == 4'h7;
                    state_d = S_FETCH_OP;
                end
            end
            default: ;
        endcase
        // Counter holds the number of wait cycles already spent in this access.
        if (req && !mem_ready_i) begin
            if (wait_q == WMAX) begin
                state_d = S_HALT;
                err_d   = 1'b1;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end
    end

    assign mem_req_o      = rst_n & req;
    assign mem_we_o       = rst_n & we;
    assign mem_addr_sel_o = rst_n & asel;
    assign pc_inc_o       = rst_n & inc;
    assign pc_load_o      = rst_n & load;
    assign alu_op_o       = alu_op;
    assign alu_src_imm_o  = src_imm;
    assign rf_we_o        = rst_n & rf_we;
    assign wb_sel_o       = rst_n & wb;
    assign rf_waddr_o     = ir_q[2:0];
    assign rf_raddr_b_o   = opnd_q[2:0];
    assign imm_o          = opnd_q;
    assign c_halt_o       = state_q == S_HALT;
    assign err_o          = err_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed per-cycle checks of the cpu_sequencer handshake, decode and halt behaviour.
module tb_cpu_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mem_req_o, mem_we_o, mem_addr_sel_o;
    logic       mem_ready_i = 1'b0;
    logic [7:0] mem_rdata_i = 8'h00;
    logic       pc_inc_o, pc_load_o;
    logic [2:0] alu_op_o;
    logic       alu_src_imm_o, rf_we_o, wb_sel_o;
    logic [2:0] rf_waddr_o, rf_raddr_b_o;
    logic [7:0] imm_o;
    logic       flag_z_i = 1'b0;
    logic       c_halt_o, err_o;
    int tests = 0;
    int fails = 0;

    cpu_sequencer #(.WAIT_MAX(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_sel_o(mem_addr_sel_o),
        .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
        .pc_inc_o(pc_inc_o), .pc_load_o(pc_load_o),
        .alu_op_o(alu_op_o), .alu_src_imm_o(alu_src_imm_o),
        .rf_we_o(rf_we_o), .wb_sel_o(wb_sel_o),
        .rf_waddr_o(rf_waddr_o), .rf_raddr_b_o(rf_raddr_b_o), .imm_o(imm_o),
        .flag_z_i(flag_z_i), .c_halt_o(c_halt_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    // Reset is released while the clock is high so the next full cycle is cycle 1.
    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready_i = 1'b0;
        mem_rdata_i = 8'h00;
        flag_z_i = 1'b0;
        repeat (3) @(posedge clk);
        #4 rst_n = 1'b1;
    endtask

    task automatic step(input logic rdy, input logic [7:0] d);
        @(negedge clk);
        mem_ready_i = rdy;
        mem_rdata_i = d;
        #1;
    endtask

    task automatic test_reset_halt();
        rst_n = 1'b0;
        mem_ready_i = 1'b1;
        mem_rdata_i = 8'hF0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (mem_req_o !== 1'b0) begin fails++; $display("FAIL rst_req got=%b exp=0", mem_req_o); end
        tests++; if (pc_inc_o !== 1'b0) begin fails++; $display("FAIL rst_inc got=%b exp=0", pc_inc_o); end
        tests++; if ({c_halt_o, err_o} !== 2'b00) begin fails++; $display("FAIL rst_halt_err got=%b exp=00", {c_halt_o, err_o}); end
        tests++; if ({imm_o, rf_waddr_o} !== 11'h0) begin fails++; $display("FAIL rst_regs got=%h/%h exp=00/0", imm_o, rf_waddr_o); end
        #3 rst_n = 1'b1;
        step(1'b1, 8'hF0);
        tests++; if ({mem_req_o, mem_addr_sel_o, pc_inc_o} !== 3'b101) begin fails++; $display("FAIL hlt_c1 got=%b exp=101", {mem_req_o, mem_addr_sel_o, pc_inc_o}); end
        step(1'b0, 8'h00);
        tests++; if ({mem_req_o, c_halt_o} !== 2'b00) begin fails++; $display("FAIL hlt_c2 got=%b exp=00", {mem_req_o, c_halt_o}); end
        step(1'b0, 8'h00);
        tests++; if ({c_halt_o, err_o, mem_req_o} !== 3'b100) begin fails++; $display("FAIL hlt_c3 got=%b exp=100", {c_halt_o, err_o, mem_req_o}); end
        step(1'b1, 8'h29);
        tests++; if ({c_halt_o, mem_req_o, pc_inc_o} !== 3'b100) begin fails++; $display("FAIL hlt_sticky got=%b exp=100", {c_halt_o, mem_req_o, pc_inc_o}); end
    endtask

    task automatic test_alu();
        int n_inc;
        do_reset();
        n_inc = 0;
        step(1'b1, 8'h29); n_inc += int'(pc_inc_o);
        step(1'b1, 8'h05); n_inc += int'(pc_inc_o);
        step(1'b0, 8'h00); n_inc += int'(pc_inc_o);
        tests++; if ({rf_we_o, wb_sel_o, rf_waddr_o, alu_op_o, alu_src_imm_o} !== {1'b1, 1'b0, 3'd1, 3'd1, 1'b1}) begin fails++; $display("FAIL add_imm got=%b%b_%0d_%0d_%b exp=10_1_1_1", rf_we_o, wb_sel_o, rf_waddr_o, alu_op_o, alu_src_imm_o); end
        tests++; if (imm_o !== 8'h05) begin fails++; $display("FAIL add_imm_val got=%h exp=05", imm_o); end
        tests++; if (n_inc !== 2) begin fails++; $display("FAIL add_inc_count got=%0d exp=2", n_inc); end
        step(1'b1, 8'h32);
        tests++; if ({rf_we_o, mem_req_o} !== 2'b01) begin fails++; $display("FAIL add_we_pulse got=%b exp=01", {rf_we_o, mem_req_o}); end
        step(1'b1, 8'h03);
        step(1'b0, 8'h00);
        tests++; if ({rf_we_o, alu_op_o, alu_src_imm_o, rf_waddr_o, rf_raddr_b_o} !== {1'b1, 3'd2, 1'b0, 3'd2, 3'd3}) begin fails++; $display("FAIL sub_reg got=%b_%0d_%b_%0d_%0d exp=1_2_0_2_3", rf_we_o, alu_op_o, alu_src_imm_o, rf_waddr_o, rf_raddr_b_o); end
        step(1'b1, 8'h1D);
        step(1'b1, 8'hFF);
        step(1'b0, 8'h00);
        tests++; if ({rf_we_o, alu_op_o, alu_src_imm_o, rf_waddr_o, imm_o} !== {1'b1, 3'd0, 1'b1, 3'd5, 8'hFF}) begin fails++; $display("FAIL mov_imm got=%b_%0d_%b_%0d_%h exp=1_0_1_5_ff", rf_we_o, alu_op_o, alu_src_imm_o, rf_waddr_o, imm_o); end
    endtask

    task automatic test_load_store();
        int n_sel;
        do_reset();
        step(1'b1, 8'h72);
        step(1'b1, 8'h40);
        step(1'b0, 8'h00);
        tests++; if ({mem_req_o, rf_we_o} !== 2'b00) begin fails++; $display("FAIL ld_exec got=%b exp=00", {mem_req_o, rf_we_o}); end
        n_sel = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00);
            n_sel += int'(mem_addr_sel_o);
            tests++; if ({mem_req_o, mem_we_o, rf_we_o, wb_sel_o} !== 4'b1000) begin fails++; $display("FAIL ld_wait%0d got=%b exp=1000", i, {mem_req_o, mem_we_o, rf_we_o, wb_sel_o}); end
        end
        step(1'b1, 8'hAB);
        n_sel += int'(mem_addr_sel_o);
        tests++; if ({rf_we_o, wb_sel_o, rf_waddr_o} !== {1'b1, 1'b1, 3'd2}) begin fails++; $display("FAIL ld_ready got=%b%b_%0d exp=11_2", rf_we_o, wb_sel_o, rf_waddr_o); end
        tests++; if (n_sel !== 4) begin fails++; $display("FAIL ld_sel_cycles got=%0d exp=4", n_sel); end
        step(1'b1, 8'h83);
        tests++; if ({mem_req_o, mem_addr_sel_o, pc_inc_o, rf_we_o} !== 4'b1010) begin fails++; $display("FAIL ld_next_fetch got=%b exp=1010", {mem_req_o, mem_addr_sel_o, pc_inc_o, rf_we_o}); end
        step(1'b0, 8'h00);
        tests++; if ({mem_req_o, pc_inc_o} !== 2'b10) begin fails++; $display("FAIL st_opnd_wait got=%b exp=10", {mem_req_o, pc_inc_o}); end
        step(1'b1, 8'h50);
        step(1'b0, 8'h00);
        step(1'b1, 8'h00);
        tests++; if ({mem_req_o, mem_we_o, mem_addr_sel_o, rf_we_o} !== 4'b1110) begin fails++; $display("FAIL st_mem got=%b exp=1110", {mem_req_o, mem_we_o, mem_addr_sel_o, rf_we_o}); end
        tests++; if ({imm_o, rf_waddr_o} !== {8'h50, 3'd3}) begin fails++; $display("FAIL st_addr got=%h/%0d exp=50/3", imm_o, rf_waddr_o); end
    endtask

    task automatic test_jump();
        do_reset();
        step(1'b1, 8'hA0);
        step(1'b1, 8'h10);
        step(1'b0, 8'h00);
        tests++; if (pc_load_o !== 1'b0) begin fails++; $display("FAIL jz_not_taken got=%b exp=0", pc_load_o); end
        step(1'b1, 8'hA0);
        step(1'b1, 8'h10);
        flag_z_i = 1'b1;
        step(1'b0, 8'h00);
        tests++; if ({pc_load_o, imm_o} !== {1'b1, 8'h10}) begin fails++; $display("FAIL jz_taken got=%b/%h exp=1/10", pc_load_o, imm_o); end
        step(1'b1, 8'h90);
        tests++; if (pc_load_o !== 1'b0) begin fails++; $display("FAIL jz_pulse got=%b exp=0", pc_load_o); end
        flag_z_i = 1'b0;
        step(1'b1, 8'h22);
        step(1'b0, 8'h00);
        tests++; if ({pc_load_o, imm_o, rf_we_o} !== {1'b1, 8'h22, 1'b0}) begin fails++; $display("FAIL jmp got=%b/%h/%b exp=1/22/0", pc_load_o, imm_o, rf_we_o); end
    endtask

    task automatic test_illegal();
        do_reset();
        step(1'b1, 8'hB0);
        tests++; if (pc_inc_o !== 1'b1) begin fails++; $display("FAIL ill_inc got=%b exp=1", pc_inc_o); end
        step(1'b0, 8'h00);
        tests++; if ({c_halt_o, err_o, mem_req_o} !== 3'b110) begin fails++; $display("FAIL ill_halt got=%b exp=110", {c_halt_o, err_o, mem_req_o}); end
        step(1'b1, 8'h00);
        tests++; if ({mem_req_o, pc_inc_o} !== 2'b00) begin fails++; $display("FAIL ill_no_opnd got=%b exp=00", {mem_req_o, pc_inc_o}); end
    endtask

    task automatic test_timeout();
        int n_req;
        do_reset();
        n_req = 0;
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 8'h00);
            n_req += int'(mem_req_o & ~c_halt_o);
        end
        tests++; if (n_req !== 15) begin fails++; $display("FAIL to_wait15 got=%0d exp=15", n_req); end
        step(1'b1, 8'h00);
        tests++; if ({pc_inc_o, c_halt_o} !== 2'b10) begin fails++; $display("FAIL to_boundary_accept got=%b exp=10", {pc_inc_o, c_halt_o}); end
        step(1'b0, 8'h00);
        tests++; if ({c_halt_o, mem_req_o} !== 2'b00) begin fails++; $display("FAIL to_nop_exec got=%b exp=00", {c_halt_o, mem_req_o}); end
        n_req = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00);
            n_req += int'(mem_req_o);
        end
        tests++; if (n_req !== 16) begin fails++; $display("FAIL to_wait16 got=%0d exp=16", n_req); end
        step(1'b0, 8'h00);
        tests++; if ({c_halt_o, err_o, mem_req_o} !== 3'b110) begin fails++; $display("FAIL to_halt got=%b exp=110", {c_halt_o, err_o, mem_req_o}); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1'b1, 8'h72);
        step(1'b1, 8'h40);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        tests++; if ({mem_req_o, mem_addr_sel_o} !== 2'b11) begin fails++; $display("FAIL mid_pending got=%b exp=11", {mem_req_o, mem_addr_sel_o}); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if ({mem_req_o, mem_addr_sel_o} !== 2'b00) begin fails++; $display("FAIL mid_req_drop got=%b exp=00", {mem_req_o, mem_addr_sel_o}); end
        tests++; if ({imm_o, rf_waddr_o} !== 11'h0) begin fails++; $display("FAIL mid_discard got=%h/%0d exp=00/0", imm_o, rf_waddr_o); end
        repeat (2) @(posedge clk);
        #4 rst_n = 1'b1;
        step(1'b1, 8'h00);
        tests++; if ({mem_req_o, mem_addr_sel_o, pc_inc_o} !== 3'b101) begin fails++; $display("FAIL mid_refetch got=%b exp=101", {mem_req_o, mem_addr_sel_o, pc_inc_o}); end
        step(1'b0, 8'h00);
        tests++; if ({mem_req_o, rf_we_o, c_halt_o, err_o} !== 4'b0000) begin fails++; $display("FAIL mid_nop got=%b exp=0000", {mem_req_o, rf_we_o, c_halt_o, err_o}); end
    endtask

    initial begin
        test_reset_halt();
        test_alu();
        test_load_store();
        test_jump();
        test_illegal();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
